// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: replays a packed memory bitstream as config bus writes; CFG_LOADER_TIMEOUT_EN adds a read watchdog
module cfg_stream_loader #(
  parameter int MEM_AW = 8,
  parameter int MAX_PAIRS = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [31:0]       config_addr,
  output logic [31:0]       config_data,
  output logic              config_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       pairs_written
);
  typedef enum logic [2:0] {IDLE, RD_HDR, RD_ADDR, RD_DATA, WRITE, DONE} state_t;
  state_t state, next;
  logic [MEM_AW-1:0] ptr;
  logic [15:0] count, hdr_n;
  logic pending, got, go, last, is_rd, timeout;
  if (TIMEOUT_CYCLES < 1 || MAX_PAIRS < 1 || MAX_PAIRS > 65535) begin : g_bad_cfg
    $error("cfg_stream_loader: bad TIMEOUT_CYCLES/MAX_PAIRS");
  end
  assign is_rd = state inside {RD_HDR, RD_ADDR, RD_DATA};
  assign go = start && (state == IDLE || state == DONE);
  assign got = pending && mem_rd_valid;
  assign hdr_n = (mem_rd_data[15:0] > 16'(MAX_PAIRS)) ? 16'(MAX_PAIRS) : mem_rd_data[15:0];
  assign last = (pairs_written + 16'd1) == count;
  assign mem_rd_en = is_rd && !pending;
  assign mem_addr = ptr;
  assign config_en = state == WRITE && !stall;
  assign busy = is_rd || state == WRITE;
  assign done = state == DONE;
`ifdef CFG_LOADER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] LIM = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wdog;
  assign timeout = pending && !mem_rd_valid && wdog == LIM;
  always_ff @(posedge clk) begin
    wdog <= (reset || mem_rd_en || !pending) ? '0 : wdog + 1'b1;
    error <= (reset || go) ? 1'b0 : timeout ? 1'b1 : error;
  end
`else
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? RD_HDR : state;
      RD_HDR:     next = !got ? RD_HDR : (hdr_n == 16'd0) ? DONE : RD_ADDR;
      RD_ADDR:    next = got ? RD_DATA : RD_ADDR;
      RD_DATA:    next = got ? WRITE : RD_DATA;
      WRITE:      next = stall ? WRITE : last ? DONE : RD_ADDR;
      default:    next = IDLE;
    endcase
    if (timeout) next = DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= 1'b0;
      ptr <= '0;
      count <= '0;
      pairs_written <= '0;
      config_addr <= '0;
      config_data <= '0;
    end else begin
      state <= next;
      pending <= mem_rd_en || (pending && !mem_rd_valid && !timeout);
      if (go) ptr <= '0;
      if (go) pairs_written <= '0;
      if (got) ptr <= ptr + 1'b1;
      if (got && state == RD_HDR) count <= hdr_n;
      if (got && state == RD_ADDR) config_addr <= mem_rd_data;
      if (got && state == RD_DATA) config_data <= mem_rd_data;
      if (config_en) pairs_written <= pairs_written + 16'd1;
    end
  end
endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb_cfg_stream_loader: directed bench with a latency-programmable memory responder and write logger
module tb_cfg_stream_loader;
  logic clk = 0, reset = 1, start = 0, stall = 0, mem_rd_valid = 0;
  logic mem_rd_en, config_en, busy, done, error;
  logic [7:0] mem_addr, pend_addr;
  logic [31:0] mem_rd_data = 0, config_addr, config_data, hold_a, hold_d;
  logic [15:0] pairs_written;
  logic [31:0] mem [256];
  logic mute = 0, force_valid = 0;
  int tests = 0, fails = 0, lat = 1, cnt = 0;
  logic [31:0] wa[$], wd[$];
  logic [7:0] rdlog[$];

  always #5 clk = ~clk;

  cfg_stream_loader #(.MEM_AW(8), .MAX_PAIRS(64), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .config_addr(config_addr), .config_data(config_data), .config_en(config_en),
    .busy(busy), .done(done), .error(error), .pairs_written(pairs_written));

  // Memory responder and bus logger act 1 time unit before each rising edge.
  initial forever begin
    @(negedge clk);
    #4;
    mem_rd_valid = force_valid;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_rd_valid = 1;
        mem_rd_data = mem[pend_addr];
      end
    end
    if (mem_rd_en) begin
      rdlog.push_back(mem_addr);
      pend_addr = mem_addr;
      if (!mute) cnt = lat;
    end
    if (config_en) begin
      wa.push_back(config_addr);
      wd.push_back(config_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load();
    wa.delete();
    wd.delete();
    rdlog.delete();
    start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_en"}, 32'(config_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_caddr"}, config_addr, 32'd0);
    chk({tag, "_cdata"}, config_data, 32'd0);
    chk({tag, "_pairs"}, 32'(pairs_written), 32'd0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'hDEAD_0000 | 32'(i);
    cyc(3);
    chk_idle("reset");
    reset = 0;
    cyc(2);
    chk_idle("idle");

    // Two pairs, latency 1, no stall.
    mem[0] = 32'd2; mem[1] = 32'h0001_0001; mem[2] = 32'hA5; mem[3] = 32'h0002_0003; mem[4] = 32'h5A;
    load();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", 100);
    cyc(3);
    chk("t1_pulses", wa.size(), 2);
    chk("t1_a0", wa.size() > 0 ? wa[0] : '1, 32'h0001_0001);
    chk("t1_d0", wd.size() > 0 ? wd[0] : '1, 32'hA5);
    chk("t1_a1", wa.size() > 1 ? wa[1] : '1, 32'h0002_0003);
    chk("t1_d1", wd.size() > 1 ? wd[1] : '1, 32'h5A);
    chk("t1_pairs", 32'(pairs_written), 32'd2);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_done_held", 32'(done), 32'd1);
    chk("t1_reads", rdlog.size(), 5);
    for (int i = 0; i < 5; i++) chk("t1_rd_addr", i < rdlog.size() ? 32'(rdlog[i]) : '1, i);

    // Empty bitstream, restarted from DONE.
    mem[0] = 32'hFFFF_0000;
    load();
    chk("t2_pairs_cleared", 32'(pairs_written), 32'd0);
    wait_done("t2_done", 100);
    cyc(4);
    chk("t2_pulses", wa.size(), 0);
    chk("t2_reads", rdlog.size(), 1);
    chk("t2_rd0", rdlog.size() > 0 ? 32'(rdlog[0]) : '1, 32'd0);
    chk("t2_pairs", 32'(pairs_written), 32'd0);

    // Three pairs, second write stalled; start pulsed while busy must be ignored.
    mem[0] = 32'd3; mem[1] = 32'h0003_0010; mem[2] = 32'h1111; mem[3] = 32'h0004_0020;
    mem[4] = 32'h2222; mem[5] = 32'h0005_0030; mem[6] = 32'h3333;
    load();
    for (int n = 0; n < 50 && wa.size() < 1; n++) cyc(1);
    chk("t3_first", wa.size(), 1);
    stall = 1;
    for (int n = 0; n < 50 && config_data !== 32'h2222; n++) cyc(1);
    chk("t3_cap_data", config_data, 32'h2222);
    hold_a = config_addr;
    hold_d = config_data;
    start = 1;
    for (int n = 0; n < 5; n++) begin
      cyc(1);
      start = 0;
      chk("t3_stall_en", 32'(config_en), 32'd0);
      chk("t3_stall_a", config_addr, hold_a);
      chk("t3_stall_d", config_data, hold_d);
    end
    chk("t3_stall_pulses", wa.size(), 1);
    stall = 0;
    #1;
    chk("t3_release_en", 32'(config_en), 32'd1);
    chk("t3_release_a", config_addr, 32'h0004_0020);
    wait_done("t3_done", 100);
    cyc(2);
    chk("t3_pulses", wa.size(), 3);
    chk("t3_a2", wa.size() > 2 ? wa[2] : '1, 32'h0005_0030);
    chk("t3_d2", wd.size() > 2 ? wd[2] : '1, 32'h3333);
    chk("t3_pairs", 32'(pairs_written), 32'd3);

    // Header beyond the clamp: 64 pairs only.
    mem[0] = 32'd1000;
    for (int i = 1; i <= 130; i++) mem[i] = 32'(i) * 32'h0101_0101;
    load();
    wait_done("t4_done", 2000);
    cyc(3);
    chk("t4_pulses", wa.size(), 64);
    chk("t4_pairs", 32'(pairs_written), 32'd64);
    chk("t4_reads", rdlog.size(), 129);
    chk("t4_last_rd", rdlog.size() > 0 ? 32'(rdlog[rdlog.size()-1]) : '1, 32'd128);
    chk("t4_a0", wa.size() > 0 ? wa[0] : '1, 32'h0101_0101);
    chk("t4_a63", wa.size() > 63 ? wa[63] : '1, 32'h7F7F_7F7F);
    chk("t4_d63", wd.size() > 63 ? wd[63] : '1, 32'h8080_8080);

    // Reset during RD_DATA of pair 1 with stale responses afterwards.
    mem[0] = 32'd2; mem[1] = 32'h0001_0001; mem[2] = 32'hA5; mem[3] = 32'h0002_0003; mem[4] = 32'h5A;
    lat = 3;
    load();
    for (int n = 0; n < 100 && rdlog.size() < 5; n++) cyc(1);
    chk("t5_reads_before", rdlog.size(), 5);
    reset = 1;
    cyc(1);
    reset = 0;
    force_valid = 1;
    cyc(1);
    force_valid = 0;
    cyc(3);
    chk_idle("t5_after");
    chk("t5_pulses", wa.size(), 1);
    lat = 1;
    load();
    wait_done("t5_reload_done", 100);
    cyc(1);
    chk("t5_reload_rd0", rdlog.size() > 0 ? 32'(rdlog[0]) : '1, 32'd0);
    chk("t5_reload_pulses", wa.size(), 2);
    chk("t5_reload_pairs", 32'(pairs_written), 32'd2);

    // Memory never answers the header read.
    mute = 1;
    load();
    cyc(20);
`ifdef CFG_LOADER_TIMEOUT_EN
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
`else
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
`endif
    chk("t6_pulses", wa.size(), 0);
    chk("t6_reads", rdlog.size(), 1);
    mute = 0;
    reset = 1;
    cyc(2);
    reset = 0;
    cyc(1);
    chk_idle("t6_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Configuration sequencer for the tile array.
- Fetches a packed bitstream from a word-addressed config memory and replays it as (config_addr, config_data) writes with a one-cycle config_en strobe.
- Drives the shared config bus that every tile's address matchers (pe, cb0, cb1, sb) decode: config_addr[31:16] = tile_id, config_addr[15:0] = config_id.
- Sits between the boot memory and the array top level. It is the single master of the config bus.

Parameters:
- MEM_AW, 8, config memory word-address width.
- MAX_PAIRS, 64, upper clamp on the pair count read from the header.
- TIMEOUT_CYCLES, 255, memory-response watchdog limit. Used only with CFG_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- stall  in  1  array cannot accept a config write this cycle
- mem_rd_en  out  1  read request, one-cycle pulse
- mem_addr  out  MEM_AW  read word address
- mem_rd_data  in  32  read data
- mem_rd_valid  in  1  read data valid; arrives 1 or more cycles after mem_rd_en
- config_addr  out  32  config bus address
- config_data  out  32  config bus data
- config_en  out  1  config write strobe
- busy  out  1  load in progress
- done  out  1  load finished; sticky
- error  out  1  load aborted on timeout; sticky
- pairs_written  out  16  count of completed config writes

Behaviour:
- Reset values: all outputs 0; state IDLE; internal pointer and counters 0.
- Bitstream layout:
  - word 0 = header; bits [15:0] = pair count N.
  - word 2k+1 = address of pair k; word 2k+2 = data of pair k; k = 0..N-1.
  - Effective count = min(N, MAX_PAIRS).
- States: IDLE, RD_HDR, RD_ADDR, RD_DATA, WRITE, DONE.
- IDLE:
  - start=1 → RD_HDR next cycle.
  - Clear pairs_written, done and error.
  - mem pointer ← 0.
- RD_HDR, RD_ADDR, RD_DATA:
  - mem_rd_en=1 with mem_addr=pointer on the first cycle in the state only. Exactly one read outstanding.
  - Wait for mem_rd_valid, then capture mem_rd_data and increment the pointer.
  - mem_rd_valid seen while no read is outstanding (IDLE, DONE, WRITE) is ignored.
- RD_HDR exit:
  - Effective N = 0 → DONE; no config writes occur.
  - Otherwise → RD_ADDR.
- RD_ADDR → RD_DATA on valid. RD_DATA → WRITE on valid.
- WRITE:
  - stall=1: hold in WRITE, config_en=0.
  - stall=0: config_en=1 for exactly this cycle, with config_addr/config_data holding the captured pair. pairs_written increments on the same edge the state leaves WRITE.
  - Exit: → DONE if pairs_written+1 == effective N, else → RD_ADDR.
- config_addr and config_data are registered. They change only on capture and hold their value outside WRITE. config_en is never high outside WRITE.
- busy=1 in RD_HDR, RD_ADDR, RD_DATA and WRITE.
- DONE:
  - done=1; held until start.
  - start in DONE restarts exactly as from IDLE.
- start while busy: ignored.
- Reset mid-load: next edge → IDLE with all outputs 0. A late mem_rd_valid from the aborted read is ignored.
- Pointer width MEM_AW; it wraps modulo 2^MEM_AW with no error. Loads must fit in memory; this is a software rule.

Optional Feature:
- CFG_LOADER_TIMEOUT_EN defined:
  - Watchdog counts cycles while a read is outstanding.
  - Reaching TIMEOUT_CYCLES without mem_rd_valid → DONE with error=1 and done=1; no further writes.
  - The counter clears on each mem_rd_en.
- Not defined:
  - No watchdog; the loader waits indefinitely.
  - error is tied to 0.

Test Plan:
- Header 2, pairs (0x0001_0001, 0xA5), (0x0002_0003, 0x5A), 1-cycle memory latency, stall=0 → two config_en pulses carrying exactly those values; pairs_written=2; done=1, busy=0; mem_addr sequence 0,1,2,3,4.
- Header 0 → no config_en; done=1 with no mem read after address 0; pairs_written=0.
- Header 3, stall held high for 5 cycles on the 2nd write → config_en stays low during stall and then pulses once; values stay stable throughout; total of 3 pulses.
- Header 1000, MAX_PAIRS=64 → exactly 64 writes, then done; last mem_addr=128.
- Reset asserted during RD_DATA of pair 1, stale mem_rd_valid driven the next cycle → outputs all 0, state IDLE, no config_en. A new start reloads from address 0.
- With CFG_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10, memory never responds to the header read → error=1 and done=1 after 10 cycles; no config_en. Without the macro, busy stays 1.
